// File: rtl/motor_ctrl_pkg.sv
// Shared motor-control types and limits used by the velocity setpoint path.
package motor_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RAMP     = 2'd1,
    HOLD     = 2'd2,
    STOPPING = 2'd3
  } ramp_state_t;

  // The velocity range is kept symmetric so that negating a value never overflows.
  localparam logic signed [15:0] VEL_MAX = 16'sd32767;
  localparam logic signed [15:0] VEL_MIN = -16'sd32767;

  // Fold the one asymmetric code (-32768) onto the symmetric range.
  function automatic logic signed [15:0] clamp_velocity(input logic signed [15:0] v);
    return (v == 16'sh8000) ? VEL_MIN : v;
  endfunction

endpackage

// File: rtl/ramp_tick_divider.sv
// Free-running divider: one-cycle tick every TICK_DIVIDER clocks.
module ramp_tick_divider #(
  parameter int TICK_DIVIDER = 5000
) (
  input  logic clk,
  input  logic reset,
  output logic tick_o
);

  localparam int CNT_W = (TICK_DIVIDER > 2) ? $clog2(TICK_DIVIDER) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIVIDER - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Tick while the counter sits on its last value; it wraps on that same edge.
  always_comb begin
    tick_o = (cnt_q == CNT_LAST);
    cnt_d  = tick_o ? '0 : cnt_q + 1'b1;
  end

  // Counter register, cleared only by reset and otherwise independent of any state.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/velocity_ramp_generator.sv
// Acceleration-limited setpoint ramp feeding the BLDC velocity controller.
// Commands retarget the ramp; disable ramps to zero; estop zeroes at once.
module velocity_ramp_generator
  import motor_ctrl_pkg::*;
#(
  parameter int TICK_DIVIDER = 5000,
  parameter int ACCEL_WIDTH  = 12
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    estop,
  input  logic signed [15:0]      cmd_velocity,
  input  logic [ACCEL_WIDTH-1:0]  accel_step,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  output logic signed [15:0]      desired_velocity,
  output logic                    at_target,
  output logic                    ramp_tick
);

  ramp_state_t              state_q, state_d;
  logic signed [15:0]       target_q, target_d;
  logic [ACCEL_WIDTH-1:0]   step_q, step_d;
  logic signed [15:0]       vel_q, vel_d;
  logic                     at_target_q, at_target_d;

  logic signed [31:0]       diff_w;
  logic signed [31:0]       abs_diff_w;
  logic signed [31:0]       step_w;
  logic signed [15:0]       vel_stepped;
  logic                     step_reaches;
  logic                     cmd_accept;
  logic signed [15:0]       cmd_clamped;
  logic [ACCEL_WIDTH-1:0]   cmd_step;

  ramp_tick_divider #(
    .TICK_DIVIDER (TICK_DIVIDER)
  ) u_tick (
    .clk    (clk),
    .reset  (reset),
    .tick_o (ramp_tick)
  );

  assign cmd_ready        = enable && !estop && (state_q != STOPPING);
  assign cmd_accept       = cmd_valid && cmd_ready;
  assign cmd_clamped      = clamp_velocity(cmd_velocity);
  assign cmd_step         = (accel_step == '0) ? ACCEL_WIDTH'(1) : accel_step;
  assign desired_velocity = vel_q;
  assign at_target        = at_target_q;

  // One ramp step toward the target; wide arithmetic so the difference cannot wrap.
  always_comb begin
    diff_w       = 32'(target_q) - 32'(vel_q);
    abs_diff_w   = (diff_w < 0) ? -diff_w : diff_w;
    step_w       = signed'(32'(step_q));
    step_reaches = (abs_diff_w <= step_w);
    if (step_reaches) begin
      vel_stepped = target_q;
    end else if (diff_w > 0) begin
      vel_stepped = 16'(32'(vel_q) + step_w);
    end else begin
      vel_stepped = 16'(32'(vel_q) - step_w);
    end
  end

  // Next-state logic in priority order: estop, disable, then step and command.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    step_d   = step_q;
    vel_d    = vel_q;

    if (estop) begin
      state_d  = IDLE;
      target_d = '0;
      vel_d    = '0;
    end else if (!enable && (state_q == RAMP || state_q == HOLD)) begin
      // Ramp down with whatever step was last latched.
      target_d = '0;
      state_d  = (vel_q == 16'sd0) ? IDLE : STOPPING;
    end else begin
      // A tick coinciding with acceptance still steps toward the old target.
      if (ramp_tick && (state_q == RAMP || state_q == STOPPING)) begin
        vel_d = vel_stepped;
        if (step_reaches) begin
          state_d = (state_q == RAMP) ? HOLD : IDLE;
        end
      end
      if (cmd_accept) begin
        target_d = cmd_clamped;
        step_d   = cmd_step;
        state_d  = (cmd_clamped == vel_d) ? HOLD : RAMP;
      end
    end

    at_target_d = (vel_d == target_d);
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      target_q    <= '0;
      step_q      <= ACCEL_WIDTH'(1);
      vel_q       <= '0;
      at_target_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      target_q    <= target_d;
      step_q      <= step_d;
      vel_q       <= vel_d;
      at_target_q <= at_target_d;
    end
  end

endmodule
